// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_trace_fifo
// Cycle-stamped FIFO of regfile writebacks, drained over valid/ready.
// Optional TRACE_DROP_COUNT_EN adds a saturating drop_count output.
// Rev    : 1.0
// ============================================================================
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int CYC_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ctrl_writeEnable,
    input  logic [4:0]               ctrl_writeReg,
    input  logic [31:0]              data_writeReg,
    input  logic                     trace_enable,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CYC_W-1:0]         out_cycle,
    output logic [4:0]               out_rd,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef TRACE_DROP_COUNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = CYC_W + 5 + 32;
    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [CYC_W-1:0] r_cycle;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [EW-1:0]    r_mem [DEPTH];

    logic             w_capture;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [EW-1:0]    w_head;

    assign w_capture = trace_enable & ctrl_writeEnable & (ctrl_writeReg != 5'd0);
    assign w_full    = (r_count == c_full_count);
    assign w_pop     = out_valid & out_ready & ~clear;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push    = w_capture & ~clear & (~w_full | w_pop);
    assign w_drop    = w_capture & ~clear & w_full & ~w_pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_cycle    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (trace_enable)
                r_cycle <= r_cycle + CYC_W'(1);
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - (AW+1)'(1);
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Storage has no reset; validity is carried entirely by the pointers/count.
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wptr] <= {r_cycle, ctrl_writeReg, data_writeReg};
    end

    assign w_head    = r_mem[r_rptr];
    assign out_valid = (r_count != '0);
    assign {out_cycle, out_rd, out_data} = out_valid ? w_head : '0;
    assign count     = r_count;
    assign overflow  = r_overflow;

`ifdef TRACE_DROP_COUNT_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_drop_count <= 8'd0;
        else if (clear)
            r_drop_count <= 8'd0;
        else if (w_drop && r_drop_count != 8'hFF)
            r_drop_count <= r_drop_count + 8'd1;
    end

    assign drop_count = r_drop_count;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

endmodule
`default_nettype wire

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
Captures the processor's register-file writeback stream (write enable, write register, write data) into a cycle-stamped FIFO. Sits directly downstream of the processor/regfile write port, in parallel with the regfile. It gives the test harness, or a later UART/debug drain, a hardware commit trace equivalent to the per-cycle "Wrote X into register N" log. Drained through a valid/ready interface.

Parameters:
DEPTH, 16, number of FIFO entries; power of 2, minimum 2
CYC_W, 16, width of the cycle stamp

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
ctrl_writeEnable  input  1  regfile write enable from processor
ctrl_writeReg  input  5  regfile destination register
data_writeReg  input  32  regfile write data
trace_enable  input  1  gates capture and cycle counting
clear  input  1  synchronous flush, active-high
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_cycle  output  CYC_W  cycle stamp of head entry
out_rd  output  5  register of head entry
out_data  output  32  data of head entry
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: at least one write was dropped

Behaviour:
- Reset (reset=0, asynchronous): cycle counter=0, read/write pointers=0, count=0, out_valid=0, out_cycle/out_rd/out_data=0, overflow=0. Takes effect immediately. An in-flight push or pop is discarded.
- Cycle counter: increments by 1 on every clock with trace_enable=1. Holds when trace_enable=0. Wraps 2^CYC_W-1 -> 0 with no flag.
- Capture condition: trace_enable & ctrl_writeEnable & (ctrl_writeReg != 0). Writes to x0 are never captured.
- Stamp: the counter value sampled in the capture cycle, i.e. the pre-increment value.
- Push: entry {stamp, rd, data} written at the write pointer. Pointer wraps modulo DEPTH.
- Pop: occurs when out_valid & out_ready. Read pointer advances and wraps modulo DEPTH.
- out_valid = (count != 0).
- out_cycle/out_rd/out_data reflect the head entry while out_valid=1. They are 0 when empty.
- Latency: a capture at edge N makes the entry visible (out_valid=1) after edge N. There is no same-cycle fall-through.
- Push and pop in the same cycle, not empty: both occur, count unchanged.
- Full (count=DEPTH) with push and pop in the same cycle: push accepted, count stays DEPTH, overflow not set.
- Full with push and no pop: push dropped, FIFO contents unchanged, overflow set to 1.
- overflow stays 1 until clear or reset.
- Empty with out_ready=1: no effect.
- clear=1: next edge sets pointers, count, cycle counter and overflow to 0. clear overrides any push or pop in the same cycle.
- count is registered and equals the number of stored entries.

Optional Feature:
TRACE_DROP_COUNT_EN
- Defined: adds output port drop_count (8 bits). It increments on each dropped push and saturates at 255. It is reset by reset and by clear.
- Undefined: drop_count port and logic are absent. Only the sticky overflow flag reports drops.

Test Plan:
- Reset, trace_enable=1. Write rd=5, data=0xDEADBEEF at counter=3, out_ready=0 -> next cycle out_valid=1, out_cycle=3, out_rd=5, out_data=0xDEADBEEF, count=1.
- Write rd=0, data=7 -> no capture. count stays 0, out_valid stays 0. The cycle counter still advances.
- DEPTH=16, out_ready=0, 17 consecutive writes to rd=1..17 (r17 masked to 5 bits as 17) -> count=16, overflow=1, entries hold rd 1..16 in order. drop_count=1 when TRACE_DROP_COUNT_EN is defined.
- Full FIFO, out_ready=1 plus a new write in the same cycle -> count stays 16, overflow unchanged, new entry lands at tail, head advances to the next entry.
- Continuous writes with out_ready=1, 40 cycles -> pointers wrap. Drained stamps are strictly consecutive, count never exceeds 1.
- Assert reset=0 mid-drain with count=5 -> immediately count=0, out_valid=0, overflow=0. Pulse clear with count=3 and a simultaneous write -> count=0 next cycle, counter=0.
